ctrl_signal_pipe: RTL
=====================

Name: ctrl_signal_pipe

Overview:
- Parametrised, elastic pipeline for control-signal bundles. It is the successor to the fixed 3-bit, single-stage control register between pipeline stages.
- Carries a WIDTH-bit control word through DEPTH registered stages, with a valid/ready handshake, bubble collapsing, synchronous flush and an occupancy count.
- Sits between decode/execute/memory stages of the core, wherever control signals must track data through stalls and flushes.

Parameters:
- WIDTH, 3, bits per control word (>=1).
- DEPTH, 2, number of register stages (>=1).
- OCC_W, $clog2(DEPTH+1), width of the occupancy output (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all in-flight words.
- in_valid  in  1  upstream word present.
- in_ready  out  1  block accepts in_ctrl this cycle.
- in_ctrl  in  WIDTH  upstream control word.
- out_valid  out  1  word present at the last stage.
- out_ready  in  1  downstream accepts the word.
- out_ctrl  out  WIDTH  last-stage control word, forced to 0 when out_valid=0.
- occupancy  out  OCC_W  number of valid stages, 0..DEPTH.

Behaviour:
- State: per stage k (0..DEPTH-1), valid bit v[k] and data d[k]. Stage DEPTH-1 drives the outputs.
- Reset (async on rst_n low; release is synchronous to clk): all v=0, all d=0.
  - Resulting outputs: out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
  - Reset mid-transfer discards all words; nothing is replayed.
- Stage enable (combinational, ripples from output to input):
  - e[DEPTH] = out_ready.
  - e[k] = !v[k] | e[k+1].
- On a rising edge, each stage k with e[k]=1 loads from the stage before it:
  - k>0: v[k]<=v[k-1], d[k]<=d[k-1].
  - k=0: v[0]<=in_valid&in_ready, d[0]<=in_ctrl.
  - Stages with e[k]=0 hold.
- Bubble collapse: an empty stage always loads, so gaps close even while out_ready=0.
- in_ready = e[0] & !flush. An input transfer occurs when in_valid & in_ready.
- out_valid = v[DEPTH-1] & !flush. An output transfer occurs when out_valid & out_ready.
- out_ctrl = out_valid ? d[DEPTH-1] : 0. An inactive stage never asserts control signals downstream.
- Latency and throughput:
  - Empty pipe: a word accepted at edge N is visible at out_valid after edge N+DEPTH-1, i.e. DEPTH cycles from presentation.
  - Sustained throughput is 1 word/cycle when out_ready=1.
- Full pipe (all v=1) with out_ready=0: in_ready=0 and all stages hold.
  - Full with out_ready=1: simultaneous input and output transfer in the same cycle; occupancy stays DEPTH.
- Flush (sync, highest priority below reset):
  - During the flush cycle, in_ready=0 and out_valid=0, so no transfers occur.
  - At the edge, all v<=0; d is unchanged.
  - Next cycle occupancy=0 and in_ready=1.
  - Flush held for several cycles keeps the pipe empty.
- occupancy = popcount(v), combinational from registers. It is not masked by flush.
- Word order is strictly preserved. Words are never duplicated or dropped, except by flush or reset.
- DEPTH=1 degenerates to a single register with a full-throughput handshake: in_ready = !v[0] | out_ready.

Optional Feature:
- Macro: CTRL_SIGNAL_PIPE_PARITY_EN.
- Defined:
  - Each stage stores an extra parity bit p[k] = ^in_ctrl, computed at stage-0 load and carried alongside d.
  - New output port parity_err (out, 1) = out_valid & (p[DEPTH-1] != ^d[DEPTH-1]).
  - parity_err is 0 at reset and during flush.
- Not defined: no parity storage and no parity_err port. All other behaviour is identical.

Test Plan (WIDTH=3, DEPTH=2 unless stated):
- Reset: rst_n=0 asynchronously mid-cycle with the pipe full -> immediately out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
- Latency: empty pipe, in_ctrl=3'b101 with in_valid=1 for one cycle, out_ready=1 -> out_valid=1 with out_ctrl=3'b101 exactly 2 cycles later for one cycle; occupancy goes 1,1,0.
- Stream: words 1..6 presented back to back, out_ready=1 -> outputs 1..6 on consecutive cycles after 2-cycle latency; in_ready constant 1.
- Backpressure and collapse:
  - Sequence: word 3'b011, one-cycle gap, word 3'b110, with out_ready=0 -> occupancy reaches 2 and in_ready=0.
  - Then raise out_ready -> 3'b011 then 3'b110 on consecutive cycles, with no bubble between them.
- Flush: pipe full with 3'b001 and 3'b010, flush=1 for one cycle while in_valid=1 -> out_valid=0 and in_ready=0 during the flush cycle; occupancy=0 afterwards; neither word nor the presented input ever appears.
- Parity (macro defined): force d[1] bit 0 flipped via hierarchical force while out_valid=1 -> parity_err=1 that cycle; with no force, parity_err stays 0 across all the scenarios above.

Source files
------------

// File: rtl/ctrl_signal_pipe.sv
// ctrl_signal_pipe: elastic DEPTH-stage valid/ready pipeline for WIDTH-bit control words
// Optional parity tracking per stage is enabled by defining CTRL_SIGNAL_PIPE_PARITY_EN.
module ctrl_signal_pipe #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_ctrl,
    output logic [OCC_W-1:0] occupancy
`ifdef CTRL_SIGNAL_PIPE_PARITY_EN
    ,
    output logic             parity_err
`endif
);
    logic [DEPTH-1:0]            r_v;
    logic [DEPTH-1:0][WIDTH-1:0] r_d;
    logic [DEPTH:0]              w_e;
    logic [OCC_W-1:0]            w_occ;
`ifdef CTRL_SIGNAL_PIPE_PARITY_EN
    logic [DEPTH-1:0]            r_p;
`endif

    // Stage enables ripple back from the output: an empty stage or a moving successor lets a stage load.
    always_comb begin
        w_e = '0;
        w_e[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) w_e[k] = !r_v[k] | w_e[k+1];
    end

    // Occupancy is the number of valid stages, deliberately not masked by flush.
    always_comb begin
        w_occ = '0;
        for (int k = 0; k < DEPTH; k++) w_occ = w_occ + OCC_W'(r_v[k]);
    end

    assign in_ready  = w_e[0] & !flush;
    assign out_valid = r_v[DEPTH-1] & !flush;
    assign out_ctrl  = out_valid ? r_d[DEPTH-1] : '0;
    assign occupancy = w_occ;
`ifdef CTRL_SIGNAL_PIPE_PARITY_EN
    assign parity_err = out_valid & (r_p[DEPTH-1] != ^r_d[DEPTH-1]);
`endif

    // Advance enabled stages; flush kills every valid bit but leaves data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            r_d <= '0;
`ifdef CTRL_SIGNAL_PIPE_PARITY_EN
            r_p <= '0;
`endif
        end else if (flush) begin
            r_v <= '0;
        end else begin
            if (w_e[0]) begin
                r_v[0] <= in_valid & in_ready;
                r_d[0] <= in_ctrl;
`ifdef CTRL_SIGNAL_PIPE_PARITY_EN
                r_p[0] <= ^in_ctrl;
`endif
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_e[k]) begin
                    r_v[k] <= r_v[k-1];
                    r_d[k] <= r_d[k-1];
`ifdef CTRL_SIGNAL_PIPE_PARITY_EN
                    r_p[k] <= r_p[k-1];
`endif
                end
            end
        end
    end
endmodule
